mem_port_arbiter: RTL and testbench

Shares the processor's single-port synchronous memory between the CPU control FSM (fetch/load/store) and a secondary host port used for debug load/dump.
- CPU has absolute priority. The host is served in cycles where the CPU issues no memory operation.
- If the host waits too long, the block freezes the CPU for exactly one cycle through cpu_stall, which feeds the processor clock-enable.
- Sits between the processor datapath/FSM memory signals and the memory macro.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_wait_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state encoding and sizing helpers for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      FORCE   = 2'd2,
      RESP    = 2'd3
   } arb_state_e;

   // Bits needed to hold 0..max_wait inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_wait);
      return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
   endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Host wait counter: clear, increment, saturate at MAX_WAIT.
module arb_wait_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic clock,
   input  logic resetn,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   localparam int unsigned CW = cnt_width(MAX_WAIT);
   localparam logic [CW-1:0] MAXV = CW'(MAX_WAIT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && cnt != MAXV)
         cnt <= cnt + 1'b1;
   end

   // Flags the cycle whose increment reaches MAX_WAIT, so the FSM can leave in time.
   assign hit = (cnt == MAXV) || (inc && cnt == MAXV - 1'b1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous memory between the CPU (absolute priority)
// and a debug host port, forcing a one-cycle CPU stall if the host starves.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cpu_memread,
   input  logic              cpu_memwrite,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   input  logic              host_req,
   output logic              host_ready,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              proto_err
);

   arb_state_e        state, state_next;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic              stall_q;
   logic              perr_q;
   logic              cpu_busy;
   logic              cnt_clr, cnt_inc, cnt_hit;
   logic              host_sel;

   assign cpu_busy = cpu_memread | cpu_memwrite;

   arb_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait (
      .clock  (clock),
      .resetn (resetn),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .hit    (cnt_hit)
   );

   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      host_sel   = 1'b0;
      case (state)
         IDLE: begin
            if (host_req) begin
               cnt_clr    = 1'b1;
               state_next = PENDING;
            end
         end
         PENDING: begin
            if (!cpu_busy) begin
               host_sel   = 1'b1;
               state_next = RESP;
            end else begin
               cnt_inc = 1'b1;
               if (cnt_hit)
                  state_next = FORCE;
            end
         end
         FORCE: begin
            host_sel   = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      mem_read  = cpu_memread;
      mem_write = cpu_memwrite;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (host_sel) begin
         mem_read  = ~lat_we;
         mem_write = lat_we;
         mem_addr  = lat_addr;
         mem_wdata = lat_wdata;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
         stall_q   <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state   <= state_next;
         stall_q <= (state_next == FORCE);
         if (state == IDLE && host_req) begin
            lat_we    <= host_we;
            lat_addr  <= host_addr;
            lat_wdata <= host_wdata;
         end
         if (state == RESP && !lat_we)
            rdata_q <= mem_rdata;
         if (cpu_memread && cpu_memwrite)
            perr_q <= 1'b1;
      end
   end

   // Read data arrives from the macro during RESP; bypass it so it is valid alongside the ack.
   assign host_rdata = (state == RESP && !lat_we) ? mem_rdata : rdata_q;
   assign host_ack   = (state == RESP);
   assign host_ready = resetn && (state == IDLE);
   assign cpu_stall  = stall_q;
   assign proto_err  = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model, ack scoreboard, directed scenarios.
module tb_mem_port_arbiter;

   logic       clock = 1'b0;
   logic       resetn = 1'b1;
   logic       cpu_memread = 1'b0, cpu_memwrite = 1'b0;
   logic [7:0] cpu_addr = '0, cpu_wdata = '0;
   logic       cpu_stall;
   logic       host_req = 1'b0, host_we = 1'b0;
   logic       host_ready, host_ack;
   logic [7:0] host_addr = '0, host_wdata = '0, host_rdata;
   logic       mem_read, mem_write;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = '0;
   logic       proto_err;

   mem_port_arbiter #(
      .ADDR_W   (8),
      .DATA_W   (8),
      .MAX_WAIT (15)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .cpu_memread  (cpu_memread),
      .cpu_memwrite (cpu_memwrite),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_stall    (cpu_stall),
      .host_req     (host_req),
      .host_ready   (host_ready),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_ack     (host_ack),
      .host_rdata   (host_rdata),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .proto_err    (proto_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous single-port memory macro model.
   logic [7:0] mem [256];
   always @(posedge clock) begin
      if (!resetn)
         mem[8'h10] <= 8'hA5;
      else begin
         if (mem_write) mem[mem_addr] <= mem_wdata;
         if (mem_read)  mem_rdata <= mem[mem_addr];
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   typedef struct {
      logic [7:0] data;
      int         ack_cyc;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   always @(negedge clock) begin
      if (resetn && host_ack) begin
         if (sb.size() == 0)
            check("ack_unexpected", 32'd1, 32'd0);
         else begin
            mon_e = sb.pop_front();
            check("ack_cycle", cyc, mon_e.ack_cyc);
            check("ack_rdata", {24'd0, host_rdata}, {24'd0, mon_e.data});
         end
      end
   end

   task automatic step(input logic hr, input logic hwe, input logic [7:0] ha, input logic [7:0] hwd,
                       input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cwd);
      @(posedge clock); #1;
      host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hwd;
      cpu_memread = cr; cpu_memwrite = cw; cpu_addr = ca; cpu_wdata = cwd;
      @(negedge clock);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, host_ready, 0);
      check({tag, "_ack"}, host_ack, 0);
      check({tag, "_stall"}, cpu_stall, 0);
      check({tag, "_rdata"}, host_rdata, 0);
      check({tag, "_perr"}, proto_err, 0);
   endtask

   int t0;

   initial begin
      #2 resetn = 1'b0;
      repeat (2) @(negedge clock);
      check_reset_outputs("rst");
      resetn = 1'b1;
      idle(2);

      // Host read with CPU idle: issue at T+1, ack with data at T+2.
      step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t1_ready", host_ready, 1);
      t0 = cyc;
      sb.push_back('{8'hA5, t0 + 2});
      step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t1_mem_read", mem_read, 1);
      check("t1_mem_write", mem_write, 0);
      check("t1_mem_addr", mem_addr, 8'h10);
      check("t1_stall", cpu_stall, 0);
      step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t1_stall2", cpu_stall, 0);
      idle(1);

      // Host write while CPU reads 3 cycles; issued on 4th cycle, rdata holds previous read.
      step(1, 1, 8'h20, 8'h3C, 0, 0, 8'h00, 8'h00);
      check("t2_ready", host_ready, 1);
      t0 = cyc;
      sb.push_back('{8'hA5, t0 + 5});
      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 8'h00, 8'h00, 1, 0, 8'(8'h40 + i), 8'h00);
         check("t2_cpu_read", mem_read, 1);
         check("t2_cpu_nowrite", mem_write, 0);
         check("t2_cpu_addr", mem_addr, 8'(8'h40 + i));
      end
      step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t2_host_write", mem_write, 1);
      check("t2_host_noread", mem_read, 0);
      check("t2_host_addr", mem_addr, 8'h20);
      check("t2_host_wdata", mem_wdata, 8'h3C);
      step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t2_mem20", mem[8'h20], 8'h3C);
      idle(1);

      // CPU busy every cycle: forced one-cycle stall at accept+16, ack at accept+17.
      step(1, 0, 8'h10, 8'h00, 0, 1, 8'h80, 8'h00);
      check("t3_ready", host_ready, 1);
      t0 = cyc;
      sb.push_back('{8'hA5, t0 + 17});
      for (int k = 1; k <= 18; k++) begin
         step(0, 0, 8'h00, 8'h00, 0, 1, 8'(8'h80 + k), 8'(k));
         check("t3_stall", cpu_stall, (k == 16));
         check("t3_mem_write", mem_write, (k != 16));
         check("t3_mem_read", mem_read, (k == 16));
         check("t3_mem_addr", mem_addr, (k == 16) ? 8'h10 : 8'(8'h80 + k));
      end
      idle(2);

      // host_req held high: one access per acceptance, re-accepted only in IDLE.
      step(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t4_ready0", host_ready, 1);
      t0 = cyc;
      sb.push_back('{8'h3C, t0 + 2});
      step(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t4_ready1", host_ready, 0);
      check("t4_read1", mem_read, 1);
      step(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t4_ready2", host_ready, 0);
      check("t4_noread2", mem_read, 0);
      step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t4_ready3", host_ready, 1);
      sb.push_back('{8'hA5, t0 + 5});
      step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t4_read4_addr", mem_addr, 8'h10);
      idle(3);

      // Reset during PENDING: request dropped, no ack afterwards.
      step(1, 0, 8'h10, 8'h00, 1, 0, 8'h30, 8'h00);
      check("t5_ready", host_ready, 1);
      step(0, 0, 8'h00, 8'h00, 1, 0, 8'h31, 8'h00);
      check("t5_pending", host_ready, 0);
      resetn = 1'b0;
      #1;
      check_reset_outputs("t5_rst");
      @(posedge clock); #1;
      check("t5_rst_ready", host_ready, 0);
      check("t5_rst_ack", host_ack, 0);
      @(negedge clock);
      resetn = 1'b1;
      step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      check("t5_idle_ready", host_ready, 1);
      idle(20);

      // Simultaneous read and write: passthrough, sticky proto_err until reset.
      step(0, 0, 8'h00, 8'h00, 1, 1, 8'h50, 8'h77);
      check("t6_perr_pre", proto_err, 0);
      check("t6_pass_rd", mem_read, 1);
      check("t6_pass_wr", mem_write, 1);
      check("t6_pass_addr", mem_addr, 8'h50);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
         check("t6_perr_sticky", proto_err, 1);
      end
      resetn = 1'b0;
      #1;
      check("t6_perr_reset", proto_err, 0);
      @(negedge clock);
      resetn = 1'b1;
      idle(3);

      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
